// File: rtl/uart_pkg.sv
// Shared UART definitions: baud divisor table, RX FSM state type and parity encodings.
// Divisors assume a 100 MHz clock and 16x oversampling; index 0 runs one tick per clock.
package uart_pkg;

   localparam int unsigned BAUD_W = 4;
   localparam int unsigned DIV_W  = 16;

   localparam logic [DIV_W-1:0] BAUD_DIV [16] = '{
      16'd1,    // simulation
      16'd651,  // 9600
      16'd326,  // 19200
      16'd163,  // 38400
      16'd109,  // 57600
      16'd54,   // 115200
      16'd27,   // 230400
      16'd14,   // 460800
      16'd7,    // 921600
      16'd6,    // 1000000
      16'd3,    // 2000000
      16'd2,    // 3125000
      16'd651,
      16'd651,
      16'd651,
      16'd651
   };

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop,
      StBreak
   } rx_state_t;

   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;

   // Even parity flags an odd count of ones across data and parity bit; odd parity inverts.
   function automatic logic parity_error(input logic [7:0] i_d, input logic i_pbit,
                                         input logic i_en, input logic i_type);
      return i_en & ((^{i_d, i_pbit}) ^ i_type);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Programmable oversample tick divider: pulses o_tick once every i_div clocks.
// i_clr restarts the count so the first tick lands a full period after the clear.
module uart_baud_tick
   import uart_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_clr,
   input  logic [DIV_W-1:0] i_div,
   output logic             o_tick
);

   logic [DIV_W-1:0] r_cnt;
   logic             w_term;

   // >= rather than == so a shrinking divisor can never strand the counter above it.
   assign w_term = (r_cnt >= (i_div - DIV_W'(1)));
   assign o_tick = w_term & ~i_clr;

   always_ff @(posedge i_clk) begin
      if (i_reset || i_clr) begin
         r_cnt <= '0;
      end else if (w_term) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/uart_rx_controller.sv
// UART receiver: 2-flop synchroniser, 16x-oversampled start detection, 8N1 / 8P1 framing,
// registered valid/ready byte output with parity, framing and overrun status.
module uart_rx_controller
   import uart_pkg::*;
#(
   parameter int unsigned OVS = 16
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_rx,
   input  logic [BAUD_W-1:0] i_baud,
   input  logic              i_parity_en,
   input  logic              i_parity_type,
   input  logic              i_rdy,
   output logic              o_val,
   output logic [7:0]        o_data,
   output logic              o_parity_err,
   output logic              o_frame_err,
   output logic              o_overrun
);

   localparam int unsigned         OVS_W    = $clog2(OVS);
   localparam logic [OVS_W-1:0]    OVS_HALF = OVS_W'(OVS / 2 - 1);
   localparam logic [OVS_W-1:0]    OVS_LAST = OVS_W'(OVS - 1);

   rx_state_t         r_state;
   logic [1:0]        r_sync;
   logic [OVS_W-1:0]  r_ovs_cnt;
   logic [2:0]        r_bit_idx;
   logic [7:0]        r_shift;
   logic              r_pbit;
   logic [BAUD_W-1:0] r_baud_l;
   logic              r_par_en_l;
   logic              r_par_type_l;
   logic              r_val;
   logic [7:0]        r_data;
   logic              r_parity_err;
   logic              r_frame_err;
   logic              r_overrun;

   logic              w_rx_s;
   logic              w_start_edge;
   logic              w_tick;
   logic              w_wrap;
   logic              w_perr;

   assign w_rx_s       = r_sync[1];
   assign w_start_edge = (r_state == StIdle) && !w_rx_s;
   assign w_wrap       = w_tick && (r_ovs_cnt == OVS_LAST);
   assign w_perr       = parity_error(r_shift, r_pbit, r_par_en_l, r_par_type_l);

   uart_baud_tick u_baud_tick (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clr   (w_start_edge),
      .i_div   (BAUD_DIV[r_baud_l]),
      .o_tick  (w_tick)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= StIdle;
         r_sync       <= 2'b11;
         r_ovs_cnt    <= '0;
         r_bit_idx    <= '0;
         r_shift      <= '0;
         r_pbit       <= 1'b0;
         r_baud_l     <= '0;
         r_par_en_l   <= 1'b0;
         r_par_type_l <= PARITY_EVEN;
         r_val        <= 1'b0;
         r_data       <= '0;
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_sync      <= {r_sync[0], i_rx};
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;

         if (r_val && i_rdy) begin
            r_val <= 1'b0;
         end

         unique case (r_state)
            StIdle: begin
               if (!w_rx_s) begin
                  r_state      <= StStart;
                  r_ovs_cnt    <= '0;
                  r_baud_l     <= i_baud;
                  r_par_en_l   <= i_parity_en;
                  r_par_type_l <= i_parity_type;
               end
            end

            StStart: begin
               if (w_tick) begin
                  if (r_ovs_cnt == OVS_HALF) begin
                     r_ovs_cnt <= '0;
                     r_bit_idx <= '0;
                     r_state   <= w_rx_s ? StIdle : StData;
                  end else begin
                     r_ovs_cnt <= r_ovs_cnt + OVS_W'(1);
                  end
               end
            end

            StData: begin
               if (w_tick) begin
                  r_ovs_cnt <= r_ovs_cnt + OVS_W'(1);
               end
               if (w_wrap) begin
                  r_shift[r_bit_idx] <= w_rx_s;
                  r_bit_idx          <= r_bit_idx + 3'd1;
                  if (r_bit_idx == 3'd7) begin
                     r_state <= r_par_en_l ? StParity : StStop;
                  end
               end
            end

            StParity: begin
               if (w_tick) begin
                  r_ovs_cnt <= r_ovs_cnt + OVS_W'(1);
               end
               if (w_wrap) begin
                  r_pbit  <= w_rx_s;
                  r_state <= StStop;
               end
            end

            StStop: begin
               if (w_tick) begin
                  r_ovs_cnt <= r_ovs_cnt + OVS_W'(1);
               end
               if (w_wrap) begin
                  if (w_rx_s) begin
                     // Back to idle at mid-stop so a start edge half a bit later is caught.
                     r_state <= StIdle;
                     if (!r_val || i_rdy) begin
                        r_data       <= r_shift;
                        r_parity_err <= w_perr;
                        r_val        <= 1'b1;
                     end else begin
                        r_overrun <= 1'b1;
                     end
                  end else begin
                     r_frame_err <= 1'b1;
                     r_state     <= StBreak;
                  end
               end
            end

            StBreak: begin
               if (w_rx_s) begin
                  r_state <= StIdle;
               end
            end

            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_val        = r_val;
   assign o_data       = r_data;
   assign o_parity_err = r_parity_err;
   assign o_frame_err  = r_frame_err;
   assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_controller.sv
// Scoreboard bench for uart_rx_controller: drivers push expected bytes, a monitor pops them
// on each val&rdy handshake and tallies frame_err / overrun pulses.
module tb_uart_rx_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx = 1'b1;
   logic [3:0] baud = 4'd0;
   logic       parity_en = 1'b0;
   logic       parity_type = 1'b0;
   logic       rdy = 1'b1;
   logic       val;
   logic [7:0] data;
   logic       perr;
   logic       fe;
   logic       ov;

   uart_rx_controller #(
      .OVS (16)
   ) dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_rx          (rx),
      .i_baud        (baud),
      .i_parity_en   (parity_en),
      .i_parity_type (parity_type),
      .i_rdy         (rdy),
      .o_val         (val),
      .o_data        (data),
      .o_parity_err  (perr),
      .o_frame_err   (fe),
      .o_overrun     (ov)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad = 0;
   int   fe_cnt = 0;
   int   ov_cnt = 0;
   int   val_hi = 0;
   int   last_rise_cyc = 0;
   logic val_prev = 1'b0;

   // Monitor: samples just after the falling edge, i.e. the values the next rising edge sees.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (!reset) begin
            if (val && !val_prev) last_rise_cyc = cyc;
            if (val) val_hi++;
            if (fe) fe_cnt++;
            if (ov) ov_cnt++;
            if (val && rdy) begin
               total++;
               if (sb_q.size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_byte: got data=%02h perr=%0b, required no delivery",
                           data, perr);
               end else begin
                  e = sb_q.pop_front();
                  if (data !== e.d || perr !== e.pe) begin
                     bad++;
                     $display("FAIL byte: got data=%02h perr=%0b, required data=%02h perr=%0b",
                              data, perr, e.d, e.pe);
                  end
               end
            end
         end
         val_prev = val;
      end
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [7:0] d, input logic pe);
      exp_t e;
      e.d  = d;
      e.pe = pe;
      sb_q.push_back(e);
   endtask

   task automatic drive(input logic b, input int n);
      rx = b;
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] d, input logic pen, input logic pb, input logic stopb,
                       input int bc);
      drive(1'b0, bc);
      for (int i = 0; i < 8; i++) drive(d[i], bc);
      if (pen) drive(pb, bc);
      drive(stopb, bc);
   endtask

   task automatic wait_drain(input string name, input int max);
      int n = 0;
      while (sb_q.size() != 0 && n < max) begin
         @(negedge clk);
         n++;
      end
      check(name, sb_q.size(), 0);
   endtask

   initial begin
      int c0;
      int f0;
      int o0;
      int v0;

      repeat (3) @(negedge clk);
      check("reset_outputs", {val, data, perr, fe, ov}, 12'h000);
      reset = 1'b0;
      drive(1'b1, 20);

      // 8N1 at one tick per clock: val rises 155 clocks after the line falls.
      val_hi = 0;
      c0 = cyc;
      push_exp(8'hA5, 1'b0);
      send(8'hA5, 1'b0, 1'b0, 1'b1, 16);
      drive(1'b1, 16);
      check("t1_latency", last_rise_cyc - c0, 155);
      check("t1_val_width", val_hi, 1);
      wait_drain("t1_drain", 50);

      // Parity variants, sent back-to-back.
      parity_en = 1'b1;
      parity_type = 1'b0;
      push_exp(8'h07, 1'b0);
      send(8'h07, 1'b1, 1'b1, 1'b1, 16);
      push_exp(8'h07, 1'b1);
      send(8'h07, 1'b1, 1'b0, 1'b1, 16);
      parity_type = 1'b1;
      push_exp(8'h07, 1'b0);
      send(8'h07, 1'b1, 1'b0, 1'b1, 16);
      push_exp(8'h07, 1'b1);
      send(8'h07, 1'b1, 1'b1, 1'b1, 16);
      drive(1'b1, 16);
      wait_drain("t2_drain", 50);

      // Framing error followed by a held break, then recovery.
      parity_en = 1'b0;
      parity_type = 1'b0;
      f0 = fe_cnt;
      v0 = val_hi;
      send(8'h3C, 1'b0, 1'b0, 1'b0, 16);
      drive(1'b0, 40);
      drive(1'b1, 20);
      check("t3_frame_err_pulses", fe_cnt - f0, 1);
      check("t3_no_val", val_hi - v0, 0);
      push_exp(8'h55, 1'b0);
      send(8'h55, 1'b0, 1'b0, 1'b1, 16);
      drive(1'b1, 16);
      wait_drain("t3_drain", 50);

      // Start glitch shorter than half a bit is rejected.
      v0 = val_hi;
      drive(1'b0, 5);
      drive(1'b1, 40);
      check("t4_glitch_no_val", val_hi - v0, 0);
      push_exp(8'h3A, 1'b0);
      send(8'h3A, 1'b0, 1'b0, 1'b1, 16);
      drive(1'b1, 16);
      wait_drain("t4_drain", 50);

      // Overrun: second byte dropped while the first is still pending.
      rdy = 1'b0;
      o0 = ov_cnt;
      push_exp(8'h11, 1'b0);
      send(8'h11, 1'b0, 1'b0, 1'b1, 16);
      send(8'h22, 1'b0, 1'b0, 1'b1, 16);
      drive(1'b1, 16);
      check("t5_overrun_pulses", ov_cnt - o0, 1);
      check("t5_held_data", data, 8'h11);
      check("t5_val_held", val, 1'b1);
      rdy = 1'b1;
      @(negedge clk);
      #2;
      check("t5_val_drop", val, 1'b0);
      wait_drain("t5_drain", 4);

      // Reset in the middle of the data bits of 0xF0.
      drive(1'b0, 16);
      drive(1'b0, 16);
      drive(1'b0, 16);
      reset = 1'b1;
      rx = 1'b1;
      @(negedge clk);
      #2;
      check("t6_reset_outputs_a", {val, data, perr, fe, ov}, 12'h000);
      @(negedge clk);
      #2;
      check("t6_reset_outputs_b", {val, data, perr, fe, ov}, 12'h000);
      @(negedge clk);
      reset = 1'b0;
      drive(1'b1, 20);
      push_exp(8'h0F, 1'b0);
      send(8'h0F, 1'b0, 1'b0, 1'b1, 16);
      drive(1'b1, 16);
      wait_drain("t6_drain", 50);

      // Divisor 2 with even parity; mid-frame changes to baud/parity must be ignored.
      baud = 4'd11;
      parity_en = 1'b1;
      parity_type = 1'b0;
      f0 = fe_cnt;
      push_exp(8'h96, 1'b0);
      fork
         send(8'h96, 1'b1, 1'b0, 1'b1, 32);
         begin
            repeat (100) @(negedge clk);
            baud = 4'd0;
            parity_en = 1'b0;
            parity_type = 1'b1;
         end
      join
      drive(1'b1, 32);
      wait_drain("t7_drain", 100);
      check("t7_no_frame_err", fe_cnt - f0, 0);

      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_rx_controller.md
# uart_rx_controller

Receive-side UART controller: the stage downstream of the transmit controller, consuming the serial `tx` line it drives. Synchronises the asynchronous `rx` input, detects start bits with 16x oversampling, samples 8 data bits LSB-first, an optional parity bit and one stop bit. Delivers each byte through a registered valid/ready output with parity, framing and overrun status.

## Interface
- `OVS`, 16: oversample ticks per bit; must be a power of two, minimum 8.
- `clk`  in  1  clock, all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial line, idle high.
- `baud`  in  4  baud select; indexes `BAUD_DIV` in `uart_pkg`.
- `parity_en`  in  1  1 = a parity bit follows D7.
- `parity_type`  in  1  0 = even, 1 = odd.
- `rdy`  in  1  downstream accepts the byte.
- `val`  out  1  byte valid.
- `data`  out  8  received byte.
- `parity_err`  out  1  parity mismatch; qualified by `val`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled 0.
- `overrun`  out  1  one-cycle pulse: frame completed while `val` was still high.

## Operation
- Synchroniser: two flops on `rx`, both reset to 1. All logic uses `rx_s`, the second-flop output.
- Tick generator: `div_cnt` counts 0..`BAUD_DIV[baud_l]`-1 and pulses `tick` on the terminal count. It is cleared on start-edge detection. `baud_l`, `par_en_l` and `par_type_l` are latched at start-edge detection; mid-frame changes to `baud`, `parity_en` or `parity_type` have no effect.
- `ovs_cnt` (log2(OVS) bits) increments on each `tick`, wraps at OVS-1 and is cleared on state entry.
- States:
  - IDLE: `rx_s`==0 -> START.
  - START: at tick `ovs_cnt`==OVS/2-1 (mid-bit), `rx_s`==0 -> DATA and `ovs_cnt` cleared; else -> IDLE (glitch rejected).
  - DATA: sample `rx_s` into `shift[bit_idx]` each time `ovs_cnt` wraps (one bit period after mid-start). After bit 7 -> PARITY if `par_en_l`, else STOP.
  - PARITY: sample one bit -> STOP.
  - STOP: sample one bit.
    - Sample 1 -> IDLE and deliver.
    - Sample 0 -> pulse `frame_err`, discard the byte -> BREAK.
  - BREAK: wait for `rx_s`==1 -> IDLE.
- Parity: `perr` = ^{shift, pbit} ^ `par_type_l` (even: total number of ones is even). When parity is disabled, `perr`=0.
- Deliver:
  - If `val`==0: load `data`<=shift and `parity_err`<=perr, set `val`=1.
  - If `val`==1: the new byte is dropped, `overrun` pulses, and `data` is unchanged.
  - If `val&rdy` occurs in the same cycle as a deliver, the new byte loads and `val` stays 1, with no overrun.
- Handshake: `val` is held with stable `data`/`parity_err` until `val&rdy`, then it clears next cycle unless a new deliver occurs that cycle.

## Timing
- Reset values:
  - `val`, `frame_err`, `overrun`, `parity_err` = 0.
  - `data` = 0x00.
  - State IDLE; all counters 0; synchroniser 1.
- Input latency: 2 cycles from `rx` to `rx_s`.
- Sample points: mid-bit ±1 tick. Bit n is sampled at (OVS/2 + OVS·(n+1)) ticks after the start edge, with the start bit as n=-1.
- Output latency: `val` rises the cycle after the stop-bit sample tick. The `frame_err` and `overrun` pulses occur in that same cycle.
- Throughput: back-to-back frames. IDLE is re-entered mid-stop-bit, so a start edge half a bit later is caught.
- Reset asserted mid-frame returns the block to IDLE in one cycle, and the partial byte is lost.

## Structure
- `uart_pkg`: `BAUD_DIV` localparam array [16] of 16-bit divisors (index 0 = 1 for simulation), the `rx_state_t` enum, and `PARITY_EVEN`/`PARITY_ODD` constants.
- Sub-module `uart_baud_tick`: divider with `clr`, `div`, and `tick` output; shared later with the TX controller.
- The synchroniser stays inline.

## Test plan
- `baud`=0, parity off, send 0xA5 with one stop bit, `rdy`=1 -> `val` for 1 cycle, `data`=0xA5, `parity_err`=0, 1 cycle after the stop sample.
- Even parity, send 0x07 with pbit=1 -> `parity_err`=0. Repeat with pbit=0 -> `data`=0x07, `parity_err`=1. Odd parity with pbit=0 -> `parity_err`=0.
- Stop bit driven 0 on 0x3C -> `frame_err` pulses once, `val` stays 0. Line held low 40 cycles, then high, then 0x55 sent -> `data`=0x55.
- `rx` low pulse of 5 ticks, shorter than OVS/2 -> no `val`, state back to IDLE.
- `rdy`=0, send 0x11 then 0x22 back-to-back -> `data`=0x11 held, `overrun` pulse at the end of the second frame. Then `rdy`=1 -> 0x11 accepted, `val` drops.
- Assert `reset` mid-DATA of 0xF0, release, send 0x0F -> only 0x0F delivered, all outputs 0 during reset.
